// File: rtl/pipe_run_monitor_pkg.sv
// Shared definitions for the run/halt monitor: state encodings and helpers.
package pipe_run_monitor_pkg;

    // Monitor states; the encodings are also decoded by the OLED status formatter.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_DRAIN   = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    // The monitor is "busy" while the program runs or its pipeline drains.
    function automatic logic state_busy(input state_t s);
        return (s == S_RUN) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/pipe_run_monitor_if.sv
// Opcode stream in, status and counters out, between the processor and the monitor.
interface pipe_run_monitor_if #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
);
    logic             start;
    logic             clear;
    logic [OP_W-1:0]  op;
    logic             op_valid;
    logic             busy;
    logic             done;
    logic             done_pulse;
    logic             timed_out;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] halt_cycle;

    // Processor / debug side: drives control and opcodes, reads status.
    modport master (
        output start, clear, op, op_valid,
        input  busy, done, done_pulse, timed_out, cycle_count, instr_count, halt_cycle
    );

    // Monitor side.
    modport slave (
        input  start, clear, op, op_valid,
        output busy, done, done_pulse, timed_out, cycle_count, instr_count, halt_cycle
    );
endinterface

// File: rtl/pipe_run_monitor_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         sysclk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         at_max
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max = (cnt_q == {W{1'b1}});
    assign q      = cnt_q;

    // Next count: clear wins, otherwise step unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge sysclk) begin
        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pipe_run_monitor.sv
// Run/halt monitor: counts run cycles and retired instructions, detects the
// halt opcode, drains the pipeline, and flags done or watchdog timeout.
module pipe_run_monitor
    import pipe_run_monitor_pkg::*;
#(
    parameter int              OP_W         = 6,
    parameter logic [OP_W-1:0] HALT_OP      = {OP_W{1'b1}},
    parameter int              DRAIN_CYCLES = 10,
    parameter int              CNT_W        = 32,
    parameter int              TIMEOUT      = 0,
    parameter bit              AUTO_START   = 1'b1
) (
    input logic               sysclk,
    input logic               rst,
    pipe_run_monitor_if.slave bus
);
    localparam int                 DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WD_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   halt_cycle_q, halt_cycle_d;
    logic               done_pulse_q, done_pulse_d;

    logic               halt;
    logic               wd_hit;
    logic               cnt_clr;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [CNT_W-1:0]   ins_cnt;
    logic               cyc_at_max;
    logic               ins_at_max;
    logic               unused_at_max;

    assign halt    = bus.op_valid && (bus.op == HALT_OP);
    // The watchdog fires on the last allowed run cycle, so cycle_count lands on TIMEOUT.
    assign wd_hit  = (TIMEOUT > 0) && (cyc_cnt == WD_LAST);
    assign cnt_clr = rst || bus.clear;

    // Saturation never changes state, so the at_max flags are informational only.
    assign unused_at_max = cyc_at_max & ins_at_max;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .sysclk (sysclk),
        .clr    (cnt_clr),
        .inc    (state_busy(state_q)),
        .q      (cyc_cnt),
        .at_max (cyc_at_max)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .sysclk (sysclk),
        .clr    (cnt_clr),
        .inc    ((state_q == S_RUN) && bus.op_valid),
        .q      (ins_cnt),
        .at_max (ins_at_max)
    );

    // State, drain counter, captured halt cycle and completion pulse registers.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            drain_q      <= '0;
            halt_cycle_q <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            halt_cycle_q <= halt_cycle_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    // Next-state logic; clear returns to IDLE from anywhere and beats start.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (AUTO_START || bus.start) state_d = S_RUN;
                S_RUN: begin
                    if (halt)        state_d = S_DRAIN;
                    else if (wd_hit) state_d = S_TIMEOUT;
                end
                S_DRAIN:   if (drain_q == '0) state_d = S_DONE;
                S_DONE:    state_d = S_DONE;
                S_TIMEOUT: state_d = S_TIMEOUT;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Drain countdown, halt-cycle capture (pre-increment count) and done pulse.
    always_comb begin
        drain_d      = drain_q;
        halt_cycle_d = halt_cycle_q;
        done_pulse_d = (state_q == S_DRAIN) && (state_d == S_DONE);
        if (bus.clear) begin
            drain_d      = '0;
            halt_cycle_d = '0;
        end else if ((state_q == S_RUN) && halt) begin
            drain_d      = DRAIN_INIT;
            halt_cycle_d = cyc_cnt;
        end else if ((state_q == S_DRAIN) && (drain_q != '0)) begin
            drain_d      = drain_q - 1'b1;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        bus.busy        = state_busy(state_q);
        bus.done        = (state_q == S_DONE);
        bus.timed_out   = (state_q == S_TIMEOUT);
        bus.done_pulse  = done_pulse_q;
        bus.cycle_count = cyc_cnt;
        bus.instr_count = ins_cnt;
        bus.halt_cycle  = halt_cycle_q;
    end
endmodule
